// File: rtl/fpga_cfg_loader.sv
// rtl/fpga_cfg_loader.sv - serial configuration loader for the 3x3 fpga fabric
//
// Purpose: shifts in one config bit per cfg_valid/cfg_ready handshake, MSB
// first, and checks a trailing even-parity bit. It then commits the payload
// onto the parallel config buses in a single cycle. The fabric is held
// disabled while a load runs and after a failed load.
//
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   cfg_start             begin a load (honoured in IDLE only)
//   cfg_din, cfg_valid    serial bit and its qualifier
//   cfg_ready             loader accepts a bit this cycle
//   cfg_busy              load in progress (SHIFT/PARITY/COMMIT)
//   cfg_done, cfg_err     one-cycle result pulses
//   fabric_en             config outputs hold a valid configuration
//   iostream .. sbstream  committed configuration buses
module fpga_cfg_loader #(
   parameter int IO_W   = 20,
   parameter int CB1_W  = 300,
   parameter int CBLR_W = 120,
   parameter int MUX_W  = 9,
   parameter int LUT_W  = 144,
   parameter int SB_W   = 240
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_start,
   input  logic              cfg_din,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              cfg_busy,
   output logic              cfg_done,
   output logic              cfg_err,
   output logic              fabric_en,
   output logic [IO_W-1:0]   iostream,
   output logic [CB1_W-1:0]  cbstream1,
   output logic [CBLR_W-1:0] cbstreamleft_or_right,
   output logic [MUX_W-1:0]  clb_mux_sel,
   output logic [LUT_W-1:0]  bitstream,
   output logic [SB_W-1:0]   sbstream
);

   localparam int TOTAL_BITS = IO_W + CB1_W + CBLR_W + MUX_W + LUT_W + SB_W;
   localparam int CNT_W      = $clog2(TOTAL_BITS);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL_BITS - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_PARITY = 2'd2,
      S_COMMIT = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    acc_q, acc_d;
   logic                    cmp_q, cmp_d;
   logic [TOTAL_BITS-1:0]   shadow_q, shadow_d;
   logic [TOTAL_BITS-1:0]   cfg_q, cfg_d;
   logic                    fabric_en_q, fabric_en_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;
   logic                    xfer;

   assign cfg_ready = (state_q == S_SHIFT) || (state_q == S_PARITY);
   assign cfg_busy  = (state_q != S_IDLE);
   assign xfer      = cfg_valid && cfg_ready;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      cmp_d       = cmp_q;
      shadow_d    = shadow_q;
      cfg_d       = cfg_q;
      fabric_en_d = fabric_en_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cfg_start) begin
               state_d     = S_SHIFT;
               cnt_d       = '0;
               acc_d       = 1'b0;
               fabric_en_d = 1'b0;
            end
         end
         S_SHIFT: begin
            if (xfer) begin
               shadow_d = {shadow_q[TOTAL_BITS-2:0], cfg_din};
               acc_d    = acc_q ^ cfg_din;
               cnt_d    = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_IDX) begin
                  state_d = S_PARITY;
               end
            end
         end
         S_PARITY: begin
            if (xfer) begin
               cmp_d   = (cfg_din == acc_q);
               state_d = S_COMMIT;
            end
         end
         S_COMMIT: begin
            // Whole payload lands in one edge so the fabric never sees a
            // partially updated configuration.
            if (cmp_q) begin
               cfg_d       = shadow_q;
               done_d      = 1'b1;
               fabric_en_d = 1'b1;
            end else begin
               err_d = 1'b1;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         acc_q       <= 1'b0;
         cmp_q       <= 1'b0;
         shadow_q    <= '0;
         cfg_q       <= '0;
         fabric_en_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         cmp_q       <= cmp_d;
         shadow_q    <= shadow_d;
         cfg_q       <= cfg_d;
         fabric_en_q <= fabric_en_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign cfg_done  = done_q;
   assign cfg_err   = err_q;
   assign fabric_en = fabric_en_q;

   // Payload is {sb, lut, mux, cblr, cb1, io}; iostream occupies the LSBs.
   assign iostream              = cfg_q[0 +: IO_W];
   assign cbstream1             = cfg_q[IO_W +: CB1_W];
   assign cbstreamleft_or_right = cfg_q[IO_W+CB1_W +: CBLR_W];
   assign clb_mux_sel           = cfg_q[IO_W+CB1_W+CBLR_W +: MUX_W];
   assign bitstream             = cfg_q[IO_W+CB1_W+CBLR_W+MUX_W +: LUT_W];
   assign sbstream              = cfg_q[IO_W+CB1_W+CBLR_W+MUX_W+LUT_W +: SB_W];

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// tb/tb_fpga_cfg_loader.sv - scoreboard testbench for fpga_cfg_loader
module tb_fpga_cfg_loader;

   localparam int IO_W   = 20;
   localparam int CB1_W  = 300;
   localparam int CBLR_W = 120;
   localparam int MUX_W  = 9;
   localparam int LUT_W  = 144;
   localparam int SB_W   = 240;
   localparam int TOTAL  = IO_W + CB1_W + CBLR_W + MUX_W + LUT_W + SB_W;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset, cfg_start, cfg_din, cfg_valid;
   logic              cfg_ready, cfg_busy, cfg_done, cfg_err, fabric_en;
   logic [IO_W-1:0]   iostream;
   logic [CB1_W-1:0]  cbstream1;
   logic [CBLR_W-1:0] cbstreamleft_or_right;
   logic [MUX_W-1:0]  clb_mux_sel;
   logic [LUT_W-1:0]  bitstream;
   logic [SB_W-1:0]   sbstream;

   fpga_cfg_loader dut (
      .clk                   (clk),
      .reset                 (reset),
      .cfg_start             (cfg_start),
      .cfg_din               (cfg_din),
      .cfg_valid             (cfg_valid),
      .cfg_ready             (cfg_ready),
      .cfg_busy              (cfg_busy),
      .cfg_done              (cfg_done),
      .cfg_err               (cfg_err),
      .fabric_en             (fabric_en),
      .iostream              (iostream),
      .cbstream1             (cbstream1),
      .cbstreamleft_or_right (cbstreamleft_or_right),
      .clb_mux_sel           (clb_mux_sel),
      .bitstream             (bitstream),
      .sbstream              (sbstream)
   );

   logic [TOTAL-1:0] dut_cfg;
   assign dut_cfg = {sbstream, bitstream, clb_mux_sel, cbstreamleft_or_right, cbstream1, iostream};

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit               is_done;
      logic [TOTAL-1:0] cfg;
      int               exp_cyc;
   } exp_t;

   exp_t             sb_q[$];
   logic [TOTAL-1:0] exp_cfg = '0;
   bit               mon_en  = 1'b0;
   int               checks  = 0;
   int               errors  = 0;

   task automatic chk(input string name, input logic [TOTAL-1:0] act, input logic [TOTAL-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every result pulse, and tracks the
   // configuration the fabric should currently be seeing.
   always @(negedge clk) begin
      if (mon_en) begin
         if (cfg_done || cfg_err) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pulse done=%0b err=%0b required=none", cfg_done, cfg_err);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               chk("pulse_kind", {cfg_done, cfg_err}, e.is_done ? 2'b10 : 2'b01);
               chk("pulse_cycle", cyc, e.exp_cyc);
               chk("fabric_en_at_pulse", fabric_en, e.is_done);
               if (e.is_done) exp_cfg = e.cfg;
            end
         end
         chk("cfg_outputs", dut_cfg, exp_cfg);
      end
   end

   // Reference field values for the next load.
   logic [IO_W-1:0]   f_io;
   logic [CB1_W-1:0]  f_cb1;
   logic [CBLR_W-1:0] f_cblr;
   logic [MUX_W-1:0]  f_mux;
   logic [LUT_W-1:0]  f_lut;
   logic [SB_W-1:0]   f_sb;

   task automatic new_fields();
      for (int i = 0; i < CB1_W; i++)  f_cb1[i]  = 1'($urandom);
      for (int i = 0; i < CBLR_W; i++) f_cblr[i] = 1'($urandom);
      for (int i = 0; i < SB_W; i++)   f_sb[i]   = 1'($urandom);
      f_cb1[0]  = 1'b1;
      f_cblr[0] = 1'b1;
      f_sb[0]   = 1'b1;
      f_io      = 20'hDEF7F;
      f_mux     = '0;
      for (int k = 0; k < 9; k++) f_lut[k*16 +: 16] = k[0] ? 16'hE8E8 : 16'h9696;
   endtask

   task automatic send_bit(input logic b, input bit throttle, output int ecyc);
      int g;
      g = 0;
      cfg_valid = 1'b1;
      cfg_din   = b;
      while (!cfg_ready && g < 8) begin
         @(posedge clk); #1;
         g++;
      end
      if (!cfg_ready) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout actual=0 required=1");
      end
      @(posedge clk); #1;
      ecyc = cyc;
      if (throttle) begin
         cfg_valid = 1'b0;
         cfg_din   = 1'($urandom);
         @(posedge clk); #1;
      end
   endtask

   task automatic do_load(input bit bad, input bit throttle, input int start_at,
                          input int abort_at, output int first_e, output int par_e);
      logic [TOTAL-1:0] payload;
      logic             par;
      int               e;
      exp_t             x;
      first_e = 0;
      par_e   = 0;
      payload = {f_sb, f_lut, f_mux, f_cblr, f_cb1, f_io};
      par     = (^payload) ^ bad;
      cfg_start = 1'b1;
      @(posedge clk); #1;
      cfg_start = 1'b0;
      chk("fabric_en_during_load", fabric_en, 1'b0);
      chk("busy_in_shift", cfg_busy, 1'b1);
      for (int i = 0; i < TOTAL; i++) begin
         if (i == abort_at) return;
         cfg_start = (i == start_at);
         send_bit(payload[TOTAL-1-i], throttle, e);
         cfg_start = 1'b0;
         if (i == 0) first_e = e;
      end
      send_bit(par, 1'b0, par_e);
      x.is_done = !bad;
      x.cfg     = payload;
      x.exp_cyc = par_e + 1;
      sb_q.push_back(x);
      // Bits offered during COMMIT/IDLE must be ignored.
      repeat (3) begin
         cfg_valid = 1'b1;
         cfg_din   = 1'($urandom);
         @(posedge clk); #1;
      end
      cfg_valid = 1'b0;
      chk("busy_after_load", cfg_busy, 1'b0);
      chk("ready_after_load", cfg_ready, 1'b0);
      chk("fabric_en_after_load", fabric_en, !bad);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int fe, pe;
      reset     = 1'b0;
      cfg_start = 1'b0;
      cfg_din   = 1'b0;
      cfg_valid = 1'b0;
      @(posedge clk); #1;
      // 1: reset with random inputs
      repeat (2) begin
         cfg_start = 1'($urandom);
         cfg_din   = 1'($urandom);
         cfg_valid = 1'($urandom);
         @(posedge clk); #1;
      end
      chk("reset_outputs", dut_cfg, '0);
      chk("reset_ready", cfg_ready, 1'b0);
      chk("reset_busy", cfg_busy, 1'b0);
      chk("reset_pulses", {cfg_done, cfg_err}, 2'b00);
      chk("reset_fabric_en", fabric_en, 1'b0);
      reset     = 1'b1;
      cfg_start = 1'b0;
      cfg_valid = 1'b0;
      mon_en    = 1'b1;
      @(posedge clk); #1;

      // 2: good load
      new_fields();
      do_load(1'b0, 1'b0, -1, -1, fe, pe);
      chk("plain_span", pe - fe, TOTAL);

      // 3: same payload, inverted parity
      do_load(1'b1, 1'b0, -1, -1, fe, pe);

      // 4: cfg_valid toggling, every bit takes two cycles
      new_fields();
      do_load(1'b0, 1'b1, -1, -1, fe, pe);
      chk("throttled_span", pe - fe, 2 * TOTAL);

      // 5: reset after 400 bits, then a full load
      new_fields();
      do_load(1'b0, 1'b0, -1, 400, fe, pe);
      reset     = 1'b0;
      cfg_valid = 1'($urandom);
      cfg_din   = 1'($urandom);
      @(posedge clk); #1;
      exp_cfg   = '0;
      reset     = 1'b1;
      cfg_valid = 1'b0;
      chk("midload_reset_outputs", dut_cfg, '0);
      chk("midload_reset_fabric_en", fabric_en, 1'b0);
      chk("midload_reset_busy", cfg_busy, 1'b0);
      repeat (4) begin @(posedge clk); #1; end
      do_load(1'b0, 1'b0, -1, -1, fe, pe);

      // 6: cfg_start pulsed at bit 100 must not restart the load
      new_fields();
      do_load(1'b0, 1'b0, 100, -1, fe, pe);

      // Random mix of parity errors and throttling
      repeat (3) begin
         new_fields();
         do_load(1'($urandom), 1'($urandom), -1, -1, fe, pe);
      end

      repeat (5) begin @(posedge clk); #1; end
      chk("scoreboard_empty", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
